wave_sample_reader: RTL and testbench
=====================================

Name: wave_sample_reader

Overview:
- Sample-playback stage directly downstream of Ctrl, in the BRAM read path.
- Ctrl releases bram_reader_rstn and supplies num_of_samples. The frequency divisor supplies a one-cycle tick per output sample.
- On each tick, the block fetches the next waveform word from BRAM at the current sample address and presents it, with a valid strobe, to the DAC/output stage.
- Playback wraps after num_of_samples entries, producing a periodic waveform.

Parameters:
- DATA_W, 32: BRAM word and sample_out width.
- ADDR_W, 32: bram_addr width.
- BASE_ADDR, 8: byte address of sample 0. Config words sit at addresses 0 and 4.
- ADDR_STEP, 4: byte increment per sample.
- BRAM_LAT, 2: BRAM read latency in clocks. Legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears everything.
- reader_rstn  in  1  from Ctrl bram_reader_rstn; synchronous active-low soft reset/enable.
- tick  in  1  one-cycle sample strobe from the frequency divisor.
- num_of_samples  in  32  waveform length from Ctrl; latched on leaving IDLE.
- bram_read  in  DATA_W  BRAM read data.
- bram_addr  out  ADDR_W  BRAM byte address of the current sample.
- sample_out  out  DATA_W  last fetched sample; held between fetches.
- sample_valid  out  1  one-cycle pulse when sample_out updates.
- wrap_pulse  out  1  coincides with sample_valid for the last sample (index N-1).
- overrun  out  1  sticky; a tick arrived while a fetch was in progress.

Behaviour:
- Reset (async) values:
  - state=IDLE, index=0, bram_addr=BASE_ADDR, sample_out=0.
  - sample_valid=0, wrap_pulse=0, overrun=0, lat_cnt=0, n_lat=0.
- reader_rstn=0 (synchronous, any state): same values as async reset, applied at the next edge. This aborts any fetch in progress; no sample_valid for the aborted fetch.
- IDLE:
  - When reader_rstn=1, latch n_lat<=num_of_samples.
  - If num_of_samples==0, stay in IDLE. Re-evaluate every cycle while reader_rstn=1.
  - Otherwise go to WAIT_TICK.
- WAIT_TICK:
  - bram_addr = BASE_ADDR + index*ADDR_STEP, modulo 2^ADDR_W; stable in this state.
  - On tick=1, go to FETCH with lat_cnt=BRAM_LAT-1.
- FETCH:
  - bram_addr is held.
  - lat_cnt decrements each cycle. When lat_cnt==0, go to PRESENT.
  - tick=1 in FETCH or PRESENT is dropped and sets overrun=1.
- PRESENT (one cycle):
  - On the edge entering PRESENT, sample_out<=bram_read.
  - sample_valid=1 during PRESENT; wrap_pulse=1 if index==n_lat-1.
  - At the edge leaving PRESENT:
    - index<=(index==n_lat-1) ? 0 : index+1;
    - bram_addr updates accordingly;
    - return to WAIT_TICK.
  - A tick in PRESENT is an overrun; it is not queued.
- Latency: tick high in cycle T gives sample_valid high in cycle T+BRAM_LAT+1, carrying data from the address shown during cycles T..T+BRAM_LAT.
- Minimum tick spacing without overrun: BRAM_LAT+2 clocks.
- num_of_samples changes while running are ignored until the next pass through IDLE.
- n_lat==1: every fetch reads BASE_ADDR, and wrap_pulse accompanies every sample_valid.
- sample_valid and wrap_pulse are registered; no combinational path from tick.
- Arithmetic is unsigned. Address wraps modulo 2^ADDR_W; no saturation.

Test Plan:
1. Async reset then release: assert reset mid-cycle with reader_rstn=1, N=100 -> all outputs zero and bram_addr=8 immediately; after release, state WAIT_TICK and bram_addr=8.
2. Basic fetch: N=100, BRAM_LAT=2, bram_read=0x000004E2, tick at cycle T:
   - sample_valid only at T+3;
   - sample_out=0x4E2;
   - bram_addr=12 after T+3;
   - overrun=0.
3. Wrap: N=3, ticks every 10 cycles -> bram_addr sequence 8,12,16,8,12; wrap_pulse with the 3rd and 6th sample_valid only.
4. Overrun: a second tick 2 cycles after the first -> exactly one sample_valid; overrun=1 and stays set until reader_rstn=0 clears it.
5. Soft reset mid-fetch: drop reader_rstn 1 cycle after tick -> no sample_valid; index=0, bram_addr=8, sample_out=0. Raising reader_rstn with N=0 keeps the block in IDLE, and ticks produce nothing.
6. Length latch: change num_of_samples from 100 to 5 while running -> wrap still occurs at index 99; after a reader_rstn pulse, wrap occurs at index 4.

Source files
------------

// File: rtl/wave_sample_reader.sv
// ============================================================================
// Module   : wave_sample_reader
// Function : Tick-driven BRAM sample fetcher with periodic wrap for playback.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wave_sample_reader #(
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned BASE_ADDR = 8,
   parameter int unsigned ADDR_STEP = 4,
   parameter int unsigned BRAM_LAT  = 2
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              reader_rstn_i,
   input  logic              tick_i,
   input  logic [31:0]       num_of_samples_i,
   input  logic [DATA_W-1:0] bram_read_i,
   output logic [ADDR_W-1:0] bram_addr_o,
   output logic [DATA_W-1:0] sample_out_o,
   output logic              sample_valid_o,
   output logic              wrap_pulse_o,
   output logic              overrun_o
);

   localparam logic [ADDR_W-1:0] C_BASE     = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] C_STEP     = ADDR_W'(ADDR_STEP);
   localparam logic [3:0]        C_LAT_INIT = 4'(BRAM_LAT - 1);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_TICK = 2'd1,
      S_FETCH     = 2'd2,
      S_PRESENT   = 2'd3
   } state_t;

   state_t              state_q;
   logic [31:0]         index_q;
   logic [31:0]         n_lat_q;
   logic [3:0]          lat_cnt_q;
   logic [ADDR_W-1:0]   bram_addr_q;
   logic [DATA_W-1:0]   sample_q;
   logic                valid_q;
   logic                wrap_q;
   logic                overrun_q;

   logic                last_d;
   logic [31:0]         index_d;
   logic [ADDR_W-1:0]   bram_addr_d;

   // Address advances incrementally so no multiplier is needed; wrap reloads the base.
   assign last_d      = (index_q == (n_lat_q - 32'd1));
   assign index_d     = last_d ? 32'd0 : (index_q + 32'd1);
   assign bram_addr_d = last_d ? C_BASE : (bram_addr_q + C_STEP);

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         n_lat_q     <= '0;
         lat_cnt_q   <= '0;
         bram_addr_q <= C_BASE;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         wrap_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else if (!reader_rstn_i) begin
         state_q     <= S_IDLE;
         index_q     <= '0;
         n_lat_q     <= '0;
         lat_cnt_q   <= '0;
         bram_addr_q <= C_BASE;
         sample_q    <= '0;
         valid_q     <= 1'b0;
         wrap_q      <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               n_lat_q <= num_of_samples_i;
               if (num_of_samples_i != 32'd0) begin
                  state_q <= S_WAIT_TICK;
               end
            end
            S_WAIT_TICK: begin
               if (tick_i) begin
                  state_q   <= S_FETCH;
                  lat_cnt_q <= C_LAT_INIT;
               end
            end
            S_FETCH: begin
               if (tick_i) begin
                  overrun_q <= 1'b1;
               end
               if (lat_cnt_q == 4'd0) begin
                  state_q  <= S_PRESENT;
                  sample_q <= bram_read_i;
                  valid_q  <= 1'b1;
                  wrap_q   <= last_d;
               end else begin
                  lat_cnt_q <= lat_cnt_q - 4'd1;
               end
            end
            S_PRESENT: begin
               if (tick_i) begin
                  overrun_q <= 1'b1;
               end
               index_q     <= index_d;
               bram_addr_q <= bram_addr_d;
               state_q     <= S_WAIT_TICK;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bram_addr_o    = bram_addr_q;
   assign sample_out_o   = sample_q;
   assign sample_valid_o = valid_q;
   assign wrap_pulse_o   = wrap_q;
   assign overrun_o      = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_wave_sample_reader.sv
// ============================================================================
// Module   : tb_wave_sample_reader
// Function : Directed and random stimulus against a cycle-indexed playback model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_wave_sample_reader;

   localparam int unsigned LAT  = 2;
   localparam int unsigned BASE = 8;
   localparam int unsigned STEP = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rstn = 1'b1;
   logic        tick = 1'b0;
   logic [31:0] num = 32'd100;
   logic [31:0] bram_read;
   logic [31:0] bram_addr;
   logic [31:0] sample_out;
   logic        sample_valid;
   logic        wrap_pulse;
   logic        overrun;

   logic        force_data = 1'b0;
   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory content depends on address and on the cycle, so the capture instant is observable.
   function automatic logic [31:0] fdata(input logic [31:0] a, input logic [31:0] c, input logic fd);
      return fd ? 32'h0000_04E2 : ((a * 32'h9E37_79B1) ^ c);
   endfunction

   assign bram_read = fdata(bram_addr, cyc, force_data);

   wave_sample_reader #(
      .DATA_W(32), .ADDR_W(32), .BASE_ADDR(BASE), .ADDR_STEP(STEP), .BRAM_LAT(LAT)
   ) dut (
      .clk_i            (clk),
      .reset_i          (reset),
      .reader_rstn_i    (rstn),
      .tick_i           (tick),
      .num_of_samples_i (num),
      .bram_read_i      (bram_read),
      .bram_addr_o      (bram_addr),
      .sample_out_o     (sample_out),
      .sample_valid_o   (sample_valid),
      .wrap_pulse_o     (wrap_pulse),
      .overrun_o        (overrun)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
      end
   endtask

   // Playback model: a pending fetch is a due cycle, the address is base + index*step.
   logic        m_run, m_pend, m_ovr;
   int unsigned m_due;
   logic [31:0] m_idx, m_n, m_sample;

   task automatic m_reset();
      m_run = 0; m_pend = 0; m_ovr = 0; m_due = 0;
      m_idx = 0; m_n = 0; m_sample = 0;
   endtask

   initial m_reset();

   always @(negedge clk) begin
      logic [31:0] ea;
      logic        ev;
      if (reset) m_reset();
      ea = BASE + m_idx * STEP;
      ev = m_pend && (m_due == cyc);
      chk("addr", bram_addr, ea);
      chk("sample", sample_out, m_sample);
      chk("valid", {31'd0, sample_valid}, {31'd0, ev});
      chk("wrap", {31'd0, wrap_pulse}, {31'd0, ev && (m_idx == m_n - 1)});
      chk("overrun", {31'd0, overrun}, {31'd0, m_ovr});
      if (reset) begin
      end else if (!rstn) begin
         m_reset();
      end else if (!m_run) begin
         m_n = num;
         m_run = (num != 0);
      end else if (m_pend) begin
         if (tick) m_ovr = 1;
         if (cyc == m_due - 1) m_sample = fdata(ea, cyc, force_data);
         if (cyc == m_due) begin
            m_idx = (m_idx == m_n - 1) ? 32'd0 : m_idx + 1;
            m_pend = 0;
         end
      end else if (tick) begin
         m_pend = 1;
         m_due = cyc + LAT + 1;
      end
   end

   // Inputs for one cycle; on return the DUT outputs show that same cycle.
   task automatic drv(input logic t, input logic rn, input logic [31:0] n);
      @(posedge clk);
      #1;
      tick = t; rstn = rn; num = n;
   endtask

   int vcnt, vk, wcnt, wat;
   int exp_a[6] = '{8, 12, 16, 8, 12, 16};
   logic [31:0] got_a[6];
   logic        got_w[6];

   initial begin
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      drv(0, 1, 100);
      drv(0, 1, 100);

      // Basic fetch with constant memory data
      force_data = 1'b1;
      drv(1, 1, 100);
      vcnt = 0; vk = -1;
      for (int k = 1; k <= 6; k++) begin
         drv(0, 1, 100);
         if (sample_valid) begin
            vcnt++; vk = k;
            chk("basic_data", sample_out, 32'h4E2);
         end
      end
      chk("basic_vcount", vcnt, 1);
      chk("basic_latency", vk, 3);
      chk("basic_addr", bram_addr, 32'd12);
      chk("basic_ovr", {31'd0, overrun}, 32'd0);
      force_data = 1'b0;

      // Asynchronous reset in the middle of a cycle
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("arst_addr", bram_addr, 32'd8);
      chk("arst_sample", sample_out, 32'd0);
      chk("arst_flags", {29'd0, sample_valid, wrap_pulse, overrun}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      drv(0, 1, 100);
      drv(0, 1, 100);
      chk("arst_release_addr", bram_addr, 32'd8);

      // Wrap with N=3
      drv(0, 0, 3); drv(0, 1, 3); drv(0, 1, 3);
      vcnt = 0;
      for (int i = 0; i < 6; i++) begin
         drv(1, 1, 3);
         got_a[i] = bram_addr;
         for (int k = 0; k < 9; k++) begin
            drv(0, 1, 3);
            if (sample_valid) begin
               got_w[i] = wrap_pulse;
               vcnt++;
            end
         end
      end
      chk("wrap_vcount", vcnt, 6);
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("wrap_addr%0d", i), got_a[i], exp_a[i]);
         chk($sformatf("wrap_flag%0d", i), {31'd0, got_w[i]}, {31'd0, (i == 2 || i == 5)});
      end

      // Overrun: second tick two cycles after the first
      drv(0, 0, 3); drv(0, 1, 3); drv(0, 1, 3);
      vcnt = 0;
      drv(1, 1, 3);
      drv(0, 1, 3);
      drv(1, 1, 3);
      for (int k = 0; k < 8; k++) begin
         drv(0, 1, 3);
         if (sample_valid) vcnt++;
      end
      chk("ovr_vcount", vcnt, 1);
      chk("ovr_set", {31'd0, overrun}, 32'd1);
      repeat (5) drv(0, 1, 3);
      chk("ovr_sticky", {31'd0, overrun}, 32'd1);
      drv(0, 0, 3);
      drv(0, 1, 3);
      chk("ovr_clear", {31'd0, overrun}, 32'd0);

      // Soft reset during a fetch, then N=0 keeps the block idle
      drv(0, 1, 3);
      drv(1, 1, 3);
      drv(0, 0, 3);
      vcnt = 0;
      for (int k = 0; k < 10; k++) begin
         drv(logic'(k % 2), 1, 0);
         if (sample_valid) vcnt++;
      end
      chk("soft_vcount", vcnt, 0);
      chk("soft_addr", bram_addr, 32'd8);
      chk("soft_sample", sample_out, 32'd0);

      // Length latched on leaving IDLE
      drv(0, 0, 100); drv(0, 1, 100); drv(0, 1, 5);
      vcnt = 0; wcnt = 0; wat = -1;
      for (int i = 0; i < 100; i++) begin
         for (int k = 0; k < 4; k++) begin
            drv(logic'(k == 0), 1, 5);
            if (sample_valid) begin
               vcnt++;
               if (wrap_pulse) begin wcnt++; wat = vcnt; end
            end
         end
      end
      chk("latch_wcount", wcnt, 1);
      chk("latch_wat100", wat, 100);
      drv(0, 0, 5); drv(0, 1, 5); drv(0, 1, 5);
      vcnt = 0; wcnt = 0; wat = -1;
      for (int i = 0; i < 5; i++) begin
         for (int k = 0; k < 4; k++) begin
            drv(logic'(k == 0), 1, 5);
            if (sample_valid) begin
               vcnt++;
               if (wrap_pulse) begin wcnt++; wat = vcnt; end
            end
         end
      end
      chk("latch_wcount5", wcnt, 1);
      chk("latch_wat5", wat, 5);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         logic        t, rn;
         logic [31:0] n;
         t  = ($urandom_range(0, 4) == 0);
         rn = ($urandom_range(0, 149) != 0);
         n  = ($urandom_range(0, 9) == 0) ? num + 1 : num;
         if (!rn) n = $urandom_range(0, 6);
         drv(t, rn, n);
      end
      drv(0, 1, num);
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
